serial_parallel_rx: RTL and testbench
=====================================

// Module: serial_parallel_rx
// PURPOSE
//  Receive-side neighbour of the transmit parallel_serial stage: recovers bytes from one serial lane.
//  Shifts the bitstream MSB-first and finds byte alignment by hunting for the COM character.
//  Locks after LOCK_COUNT consecutive aligned COMs, then presents parallel bytes to the 8->32 stage.
//  Transmitter sends COM on idle (valid low), so COM bytes received while locked are flagged not-valid.
//  One instance per lane.
// PARAMETERS
//  COM         8'hBC  alignment/idle character
//  LOCK_COUNT  4      consecutive byte-aligned COMs required to declare lock (range 1..15)
// PORTS
//  clk        input   1  bit-rate clock; one serial bit sampled per rising edge
//  reset      input   1  asynchronous, active-low reset
//  serial_in  input   1  serial data, MSB of each byte first
//  data_out   output  8  last byte recovered while locked; held between boundaries
//  valid_out  output  1  data_out is a payload byte (not COM); held with data_out
//  byte_tick  output  1  one-clk pulse on each cycle data_out/valid_out update
//  active     output  1  lane is aligned (LOCKED state)
// BEHAVIOUR
//  Reset (reset==0, async): state=SEARCH, shift reg sr=0, bit_cnt=0, com_cnt=0;
//   data_out=8'h00, valid_out=0, byte_tick=0, active=0. Outputs return to these values immediately.
//  Every clk: sr <= {sr[6:0], serial_in}. Define window w = {sr[6:0], serial_in} (combinational).
//  bit_cnt: 3-bit, wraps 7->0. "Boundary" = cycle where bit_cnt==7 (eighth bit of a byte arrives).
//  FSM:
//   SEARCH: bit_cnt ignored. If w==COM: bit_cnt<=0, com_cnt<=1, state<=COUNT
//    (or LOCKED directly if LOCK_COUNT==1). Else stay; COM checked on every bit (any offset).
//   COUNT: bit_cnt increments each clk. At boundary: if w==COM then com_cnt++; if the new
//    com_cnt==LOCK_COUNT then state<=LOCKED and active<=1 on that edge.
//    If w!=COM then state<=SEARCH, com_cnt<=0.
//   LOCKED: bit_cnt increments. At boundary: data_out<=w, valid_out<=(w!=COM), byte_tick<=1.
//    Other cycles: byte_tick<=0, data_out/valid_out hold. LOCKED exits only via reset.
//  Latency: last bit of a byte on serial_in at edge N -> data_out/valid_out/byte_tick at edge N.
//   These are registered outputs, visible from edge N until edge N+8.
//  The COM byte that completes lock is not presented; first data_out update is at the next boundary.
//  While in SEARCH/COUNT: data_out, valid_out and byte_tick stay at reset values (0); active stays 0.
//  A non-COM byte at a boundary in COUNT discards partial lock; the next hunt starts on the
//   following clk (overlapping COM at shifted offset is found by normal SEARCH scanning).
//  com_cnt saturates at LOCK_COUNT; no overflow.
// TESTING
//  1 Hold reset low 5 clk, serial_in toggling -> data_out=00, valid_out=0, byte_tick=0,
//    active=0 throughout; release -> still 0 until lock.
//  2 Send BC x4 aligned from the first bit -> active=1 on the 32nd bit edge; then send A5
//    -> 8 clk later data_out=A5, valid_out=1, one-clk byte_tick.
//  3 Send 3 junk bits 101, then BC x4, then 3C,FF -> lock despite offset; data_out=3C then FF
//    at successive boundaries 8 clk apart.
//  4 Send BC,BC,BC,5A -> no lock (active=0, state back to SEARCH); then BC x4, 11
//    -> lock, data_out=11 valid_out=1.
//  5 Locked, send BC -> data_out=BC, valid_out=0, byte_tick pulses; next 77 -> valid_out=1.
//  6 Locked mid-byte (bit 4), assert reset -> all outputs 0 asynchronously;
//    release -> relock required (4 BC) before any byte_tick.

Source files
------------

// File: rtl/serial_parallel_rx.sv
// Serial-lane byte receiver: hunts for the COM character at any bit offset, locks after
// LOCK_COUNT consecutive aligned COMs, then presents each received byte with a one-clk tick.
module serial_parallel_rx #(
    parameter logic [7:0]  COM        = 8'hBC,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_tick,
    output logic       active
);

    typedef enum logic [1:0] {
        SEARCH,
        COUNT,
        LOCKED
    } state_t;

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

    state_t     state, state_d;
    // Only the seven most recent bits are kept; the eighth is serial_in itself.
    logic [6:0] sr;
    logic [7:0] w;
    logic [2:0] bit_cnt, bit_cnt_d;
    logic [3:0] com_cnt, com_cnt_d;
    logic [7:0] data_d;
    logic       valid_d;
    logic       tick_d;
    logic       boundary;
    logic       is_com;

    assign w        = {sr, serial_in};
    assign boundary = (bit_cnt == 3'd7);
    assign is_com   = (w == COM);

    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt + 3'd1;
        com_cnt_d = com_cnt;
        data_d    = data_out;
        valid_d   = valid_out;
        tick_d    = 1'b0;
        case (state)
            SEARCH: begin
                bit_cnt_d = bit_cnt;
                if (is_com) begin
                    bit_cnt_d = '0;
                    com_cnt_d = 4'd1;
                    state_d   = (LOCK_CNT == 4'd1) ? LOCKED : COUNT;
                end
            end
            COUNT: begin
                if (boundary) begin
                    if (is_com) begin
                        if (com_cnt < LOCK_CNT)
                            com_cnt_d = com_cnt + 4'd1;
                        if (com_cnt + 4'd1 == LOCK_CNT)
                            state_d = LOCKED;
                    end else begin
                        com_cnt_d = '0;
                        state_d   = SEARCH;
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    data_d  = w;
                    valid_d = !is_com;
                    tick_d  = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SEARCH;
            sr        <= '0;
            bit_cnt   <= '0;
            com_cnt   <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            byte_tick <= 1'b0;
            active    <= 1'b0;
        end else begin
            state     <= state_d;
            sr        <= w[6:0];
            bit_cnt   <= bit_cnt_d;
            com_cnt   <= com_cnt_d;
            data_out  <= data_d;
            valid_out <= valid_d;
            byte_tick <= tick_d;
            active    <= (state_d == LOCKED);
        end
    end

endmodule

// File: tb/tb_serial_parallel_rx.sv
// Directed bench for serial_parallel_rx: alignment hunt, lock, byte presentation, async reset.
module tb_serial_parallel_rx;

    logic       clk;
    logic       reset;
    logic       serial_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_tick;
    logic       active;

    int tests_run = 0;
    int fails     = 0;
    int ticks     = 0;

    serial_parallel_rx #(.COM(8'hBC), .LOCK_COUNT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .serial_in (serial_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .byte_tick (byte_tick),
        .active    (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs packed as {active, valid_out, byte_tick, data_out}
    function automatic logic [10:0] outs();
        return {active, valid_out, byte_tick, data_out};
    endfunction

    task automatic send_bit(input logic b);
        @(negedge clk);
        serial_in = b;
        @(posedge clk);
        #1;
        if (byte_tick === 1'b1) ticks++;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_byte(input logic [7:0] v);
        send_bits(v, 8);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic lock_seq();
        repeat (4) send_byte(8'hBC);
    endtask

    task automatic test_reset();
        serial_in = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            serial_in = ~serial_in;
            @(posedge clk);
            #1;
            tests_run++;
            if (outs() !== 11'h000) begin
                fails++;
                $display("FAIL reset_hold cyc%0d: got %h want 000", i, outs());
            end
        end
        @(negedge clk);
        reset = 1'b1;
        send_byte(8'h5A);
        tests_run++;
        if (outs() !== 11'h000) begin
            fails++;
            $display("FAIL reset_release: got %h want 000", outs());
        end
    endtask

    task automatic test_aligned_lock();
        do_reset();
        repeat (3) send_byte(8'hBC);
        send_bits(8'h5E, 7); // first seven bits of BC
        tests_run++;
        if (active !== 1'b0) begin
            fails++;
            $display("FAIL lock_bit31: active got %b want 0", active);
        end
        send_bit(1'b0);
        tests_run++;
        if (outs() !== 11'h400) begin
            fails++;
            $display("FAIL lock_bit32: got %h want 400", outs());
        end
        send_byte(8'hA5);
        tests_run++;
        if (outs() !== 11'h7A5) begin
            fails++;
            $display("FAIL aligned_A5: got %h want 7A5", outs());
        end
        send_bit(1'b0);
        tests_run++;
        if (outs() !== 11'h6A5) begin
            fails++;
            $display("FAIL tick_one_clk: got %h want 6A5", outs());
        end
    endtask

    task automatic test_offset_lock();
        do_reset();
        send_bits(8'h05, 3);
        lock_seq();
        tests_run++;
        if (active !== 1'b1) begin
            fails++;
            $display("FAIL offset_lock: active got %b want 1", active);
        end
        send_byte(8'h3C);
        tests_run++;
        if (outs() !== 11'h73C) begin
            fails++;
            $display("FAIL offset_3C: got %h want 73C", outs());
        end
        send_byte(8'hFF);
        tests_run++;
        if (outs() !== 11'h7FF) begin
            fails++;
            $display("FAIL offset_FF: got %h want 7FF", outs());
        end
    endtask

    task automatic test_broken_lock();
        do_reset();
        repeat (3) send_byte(8'hBC);
        send_byte(8'h5A);
        tests_run++;
        if (outs() !== 11'h000) begin
            fails++;
            $display("FAIL broken_no_lock: got %h want 000", outs());
        end
        lock_seq();
        tests_run++;
        if (outs() !== 11'h400) begin
            fails++;
            $display("FAIL relock: got %h want 400", outs());
        end
        send_byte(8'h11);
        tests_run++;
        if (outs() !== 11'h711) begin
            fails++;
            $display("FAIL relock_11: got %h want 711", outs());
        end
    endtask

    task automatic test_com_while_locked();
        send_byte(8'hBC);
        tests_run++;
        if (outs() !== 11'h5BC) begin
            fails++;
            $display("FAIL locked_com: got %h want 5BC", outs());
        end
        send_bit(1'b0);
        tests_run++;
        if (outs() !== 11'h4BC) begin
            fails++;
            $display("FAIL locked_com_hold: got %h want 4BC", outs());
        end
        send_bits(8'h77, 7);
        tests_run++;
        if (outs() !== 11'h777) begin
            fails++;
            $display("FAIL locked_77: got %h want 777", outs());
        end
    endtask

    task automatic test_async_reset();
        send_bits(8'hC0, 4); // four bits into the next byte
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if (outs() !== 11'h000) begin
            fails++;
            $display("FAIL async_reset: got %h want 000", outs());
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        ticks = 0;
        repeat (3) send_byte(8'hBC);
        send_bits(8'h5E, 7);
        tests_run++;
        if ({active, ticks[3:0]} !== 5'h00) begin
            fails++;
            $display("FAIL pre_relock: active=%b ticks=%0d want 0/0", active, ticks);
        end
        send_bit(1'b0);
        send_byte(8'h42);
        tests_run++;
        if (outs() !== 11'h742 || ticks !== 1) begin
            fails++;
            $display("FAIL relock_42: got %h ticks=%0d want 742 ticks=1", outs(), ticks);
        end
    endtask

    initial begin
        reset     = 1'b0;
        serial_in = 1'b0;
        test_reset();
        test_aligned_lock();
        test_offset_lock();
        test_broken_lock();
        test_com_while_locked();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
